interrupt_handler: RTL and testbench

INTERRUPT_HANDLER -- requirements
Module: interrupt_handler

---
 rtl/interrupt_handler.sv | 163 ++++++++++++++++
 tb/tb_interrupt_handler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_handler.sv
`default_nettype none
// ============================================================================
// interrupt_handler : prioritised cause capture, trap sequencing and special
// registers. Optional sticky pending causes with macro INT_PEND_EN. Rev 1.0
// ============================================================================
module interrupt_handler #(
  parameter int NCAUSE = 23,
  parameter int NINT   = 7,
  parameter int NREP   = 6,
  parameter int W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCAUSE-1:0] ca,
  input  logic              ue,
  input  logic [W-1:0]      pc,
  input  logic [W-1:0]      next_pc,
  input  logic [W-1:0]      ea,
  input  logic              eret,
  input  logic              sr_we,
  input  logic [W-1:0]      sr_wdata,
  output logic              jisr,
  output logic [4:0]        il,
  output logic [W-1:0]      sr,
  output logic [W-1:0]      esr,
  output logic [W-1:0]      eca,
  output logic [W-1:0]      epc,
  output logic [W-1:0]      edata,
  output logic              mode,
  output logic              fatal
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_TRAP    = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;
  localparam logic [1:0] ST_HALT    = 2'd3;

  localparam logic [NCAUSE-1:0] INT_MASK = {{(NCAUSE-NINT){1'b0}}, {NINT{1'b1}}};

  logic [1:0]        state_q, state_d;
  logic [W-1:0]      sr_q, sr_d, esr_q, esr_d, eca_q, eca_d;
  logic [W-1:0]      epc_q, epc_d, edata_q, edata_d;
  logic [4:0]        il_q, il_d;
  logic              mode_q, mode_d, msv_q, msv_d;
  logic [NCAUSE-1:0] seen_w, mca_w, enable_w;
  logic [4:0]        lo_w;
  logic              take_w, fault_w, wr_w;

  assign enable_w = {sr_q[NCAUSE-1:NINT], {NINT{1'b1}}};

`ifdef INT_PEND_EN
  logic [NCAUSE-1:0] pend_q, pend_d;

  assign seen_w = ca | pend_q;

  // Only maskable causes are remembered; a bit leaves only when it is reported in eca.
  always_comb begin
    pend_d = (pend_q | (ca & ~INT_MASK)) & ~(take_w ? mca_w : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end
`else
  assign seen_w = ca;
`endif

  assign mca_w   = seen_w & enable_w;
  assign take_w  = (state_q == ST_RUN) && ue && (|mca_w);
  assign fault_w = ue && (|ca[NINT-1:0]);
  assign wr_w    = ue && sr_we && !mode_q && !fault_w && (state_q != ST_HALT);

  always_comb begin
    lo_w = '0;
    for (int i = NCAUSE - 1; i >= 0; i--) begin
      if (mca_w[i]) lo_w = 5'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (take_w) state_d = ST_TRAP;
      ST_TRAP:    state_d = ST_HANDLER;
      ST_HANDLER: begin
        if (fault_w)        state_d = ST_HALT;
        else if (ue && eret) state_d = ST_RUN;
      end
      default:    state_d = ST_HALT;
    endcase
  end

  always_comb begin
    jisr  = (state_q == ST_TRAP);
    fatal = (state_q == ST_HALT);
  end

  always_comb begin
    sr_d    = sr_q;
    esr_d   = esr_q;
    eca_d   = eca_q;
    epc_d   = epc_q;
    edata_d = edata_q;
    il_d    = il_q;
    mode_d  = mode_q;
    msv_d   = msv_q;
    if (take_w) begin
      eca_d              = '0;
      eca_d[NCAUSE-1:0]  = mca_w;
      il_d               = lo_w;
      esr_d              = sr_q;
      sr_d               = '0;
      msv_d              = mode_q;
      mode_d             = 1'b0;
      edata_d            = ea;
      // Repeat-type causes re-execute the faulting instruction.
      epc_d              = (int'(lo_w) < NREP) ? pc : next_pc;
    end else if ((state_q == ST_HANDLER) && ue && eret && !fault_w) begin
      sr_d   = esr_q;
      mode_d = msv_q;
    end else if (wr_w) begin
      sr_d = sr_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q    <= '0;
      esr_q   <= '0;
      eca_q   <= '0;
      epc_q   <= '0;
      edata_q <= '0;
      il_q    <= '0;
      mode_q  <= 1'b0;
      msv_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      esr_q   <= esr_d;
      eca_q   <= eca_d;
      epc_q   <= epc_d;
      edata_q <= edata_d;
      il_q    <= il_d;
      mode_q  <= mode_d;
      msv_q   <= msv_d;
    end
  end

  assign sr    = sr_q;
  assign esr   = esr_q;
  assign eca   = eca_q;
  assign epc   = epc_q;
  assign edata = edata_q;
  assign il    = il_q;
  assign mode  = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_handler.sv
`default_nettype none
// tb_interrupt_handler : directed scenarios plus randomized run checked against
// a behavioural model of the trap rules.
module tb_interrupt_handler;

  localparam int NC = 23;
  localparam int NI = 7;
  localparam int NR = 6;
  localparam int RUN = 0, TRAP = 1, HANDLER = 2, HALT = 3;
`ifdef INT_PEND_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic          clk, reset, ue, eret, sr_we;
  logic [NC-1:0] ca;
  logic [7:0]    ca2;
  logic [31:0]   pc, next_pc, ea, sr_wdata;
  logic          jisr, mode, fatal, jisr2, mode2, fatal2;
  logic [4:0]    il, il2;
  logic [31:0]   sr, esr, eca, epc, edata, sr2, esr2, eca2, epc2, edata2;
  logic [167:0]  dut_vec, dut2_vec;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_st;
  logic [31:0] m_sr, m_esr, m_eca, m_epc, m_edata;
  logic [4:0]  m_il;
  logic        m_mode, m_msv;
  logic [NC-1:0] m_pend;

  interrupt_handler #(.NCAUSE(NC), .NINT(NI), .NREP(NR), .W(32)) dut (
    .clk(clk), .reset(reset), .ca(ca), .ue(ue), .pc(pc), .next_pc(next_pc), .ea(ea),
    .eret(eret), .sr_we(sr_we), .sr_wdata(sr_wdata), .jisr(jisr), .il(il), .sr(sr),
    .esr(esr), .eca(eca), .epc(epc), .edata(edata), .mode(mode), .fatal(fatal)
  );

  interrupt_handler #(.NCAUSE(8), .NINT(2), .NREP(2), .W(32)) dut2 (
    .clk(clk), .reset(reset), .ca(ca2), .ue(ue), .pc(pc), .next_pc(next_pc), .ea(ea),
    .eret(eret), .sr_we(sr_we), .sr_wdata(sr_wdata), .jisr(jisr2), .il(il2), .sr(sr2),
    .esr(esr2), .eca(eca2), .epc(epc2), .edata(edata2), .mode(mode2), .fatal(fatal2)
  );

  assign dut_vec  = {jisr, il, sr, esr, eca, epc, edata, mode, fatal};
  assign dut2_vec = {jisr2, il2, sr2, esr2, eca2, epc2, edata2, mode2, fatal2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ca = '0; ca2 = '0; ue = 1'b0; eret = 1'b0; sr_we = 1'b0; sr_wdata = '0;
  endtask

  task automatic model_reset;
    m_st = RUN; m_sr = '0; m_esr = '0; m_eca = '0; m_epc = '0; m_edata = '0;
    m_il = '0; m_mode = 1'b0; m_msv = 1'b0; m_pend = '0;
  endtask

  task automatic do_reset;
    idle;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset;
  endtask

  function automatic logic [167:0] exp_vec;
    return {m_st == TRAP, m_il, m_sr, m_esr, m_eca, m_epc, m_edata, m_mode, m_st == HALT};
  endfunction

  // Behavioural rules for one clock edge given the currently driven inputs.
  task automatic model_step;
    logic [NC-1:0] v, pend_n;
    int lo;
    bit wr;
    v = '0;
    for (int i = 0; i < NC; i++)
      if ((ca[i] || (PEND && i >= NI && m_pend[i])) && (i < NI || m_sr[i])) v[i] = 1'b1;
    pend_n = m_pend;
    if (PEND) for (int i = NI; i < NC; i++) if (ca[i]) pend_n[i] = 1'b1;
    wr = ue && sr_we && !m_mode && (ca[NI-1:0] == 0) && (m_st != HALT);
    case (m_st)
      RUN: begin
        if (ue && v != 0) begin
          lo = NC;
          for (int i = NC - 1; i >= 0; i--) if (v[i]) lo = i;
          m_eca = {9'b0, v}; m_il = 5'(lo); m_esr = m_sr; m_sr = '0;
          m_msv = m_mode; m_mode = 1'b0; m_edata = ea;
          m_epc = (lo < NR) ? pc : next_pc;
          pend_n = pend_n & ~v;
          m_st = TRAP;
        end else if (wr) m_sr = sr_wdata;
      end
      TRAP: begin
        m_st = HANDLER;
        if (wr) m_sr = sr_wdata;
      end
      HANDLER: begin
        if (ue && ca[NI-1:0] != 0) m_st = HALT;
        else if (ue && eret) begin m_sr = m_esr; m_mode = m_msv; m_st = RUN; end
        else if (wr) m_sr = sr_wdata;
      end
      default: ;
    endcase
    m_pend = pend_n;
  endtask

  task automatic write_sr(input logic [31:0] val);
    idle; ue = 1'b1; sr_we = 1'b1; sr_wdata = val;
    tick;
    idle;
  endtask

  task automatic test_reset;
    do_reset;
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_main got=%h exp=0", dut_vec); end
    n_tests++;
    if (dut2_vec !== '0) begin n_fail++; $display("FAIL reset_small got=%h exp=0", dut2_vec); end
  endtask

  task automatic test_basic_trap;
    logic [31:0] p, a;
    do_reset;
    write_sr(32'h400);
    n_tests++;
    if (sr !== 32'h400) begin n_fail++; $display("FAIL sr_write got=%h exp=%h", sr, 32'h400); end
    p = $urandom & 32'hFFFF_FFFC; a = $urandom;
    ca = '0; ca[10] = 1'b1; ue = 1'b1; pc = p; next_pc = p + 4; ea = a;
    tick;
    n_tests++;
    if ({jisr, il, eca, epc, sr, mode, esr, edata} !== {1'b1, 5'd10, 32'h400, p + 32'd4, 32'h0, 1'b0, 32'h400, a}) begin
      n_fail++;
      $display("FAIL trap_entry got=%h exp=%h", {jisr, il, eca, epc, sr, mode, esr, edata},
               {1'b1, 5'd10, 32'h400, p + 32'd4, 32'h0, 1'b0, 32'h400, a});
    end
    idle; tick;
    n_tests++;
    if (jisr !== 1'b0) begin n_fail++; $display("FAIL jisr_one_cycle got=%b exp=0", jisr); end
  endtask

  task automatic test_priority_eret_fatal;
    logic [31:0] p;
    do_reset;
    write_sr(32'h1000);
    p = $urandom & 32'hFFFF_FFFC;
    ca = '0; ca[3] = 1'b1; ca[12] = 1'b1; ue = 1'b1; pc = p; next_pc = p + 4;
    tick;
    n_tests++;
    if ({jisr, il, eca, epc} !== {1'b1, 5'd3, 32'h1008, p}) begin
      n_fail++; $display("FAIL priority_repeat got=%h exp=%h", {jisr, il, eca, epc}, {1'b1, 5'd3, 32'h1008, p});
    end
    idle; tick;
    idle; ue = 1'b1; eret = 1'b1;
    tick;
    n_tests++;
    if ({jisr, sr, mode, fatal} !== {1'b0, 32'h1000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL eret_restore got=%h exp=%h", {jisr, sr, mode, fatal}, {1'b0, 32'h1000, 1'b0, 1'b0});
    end
    idle; ca[12] = 1'b1; ue = 1'b1;
    tick;
    n_tests++;
    if ({jisr, il} !== {1'b1, 5'd12}) begin
      n_fail++; $display("FAIL retake got=%h exp=%h", {jisr, il}, {1'b1, 5'd12});
    end
    idle; tick;
    ca[1] = 1'b1; ue = 1'b1;
    tick;
    n_tests++;
    if ({fatal, jisr} !== 2'b10) begin n_fail++; $display("FAIL fatal_set got=%b exp=10", {fatal, jisr}); end
    for (int k = 0; k < 5; k++) begin
      idle; ue = 1'b1; eret = 1'(k % 2); ca = NC'($urandom);
      tick;
      n_tests++;
      if ({fatal, jisr} !== 2'b10) begin n_fail++; $display("FAIL fatal_hold got=%b exp=10", {fatal, jisr}); end
    end
    do_reset;
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL fatal_reset got=%h exp=0", dut_vec); end
  endtask

  task automatic test_reset_mid_trap;
    do_reset;
    ca[0] = 1'b1; ue = 1'b1;
    tick;
    n_tests++;
    if (jisr !== 1'b1) begin n_fail++; $display("FAIL mid_trap_entry got=%b exp=1", jisr); end
    do_reset;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_tests++;
      if (dut_vec !== '0) begin n_fail++; $display("FAIL abort_trap got=%h exp=0", dut_vec); end
    end
    ca[5] = 1'b1; ue = 1'b1;
    tick; idle; tick;
    do_reset;
    tick;
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL abort_handler got=%h exp=0", dut_vec); end
  endtask

  task automatic test_mask_hold;
    logic [31:0] p;
    do_reset;
    ca[20] = 1'b1; ue = 1'b1;
    tick;
    n_tests++;
    if ({jisr, eca} !== 33'h0) begin n_fail++; $display("FAIL masked got=%h exp=0", {jisr, eca}); end
    write_sr(32'h10_0000);
    p = $urandom & 32'hFFFF_FFFC;
    ca[20] = 1'b1; ue = 1'b0; pc = p; next_pc = p + 4;
    tick;
    n_tests++;
    if (jisr !== 1'b0) begin n_fail++; $display("FAIL ue_hold got=%b exp=0", jisr); end
    ue = 1'b1;
    tick;
    n_tests++;
    if ({jisr, il, epc} !== {1'b1, 5'd20, p + 32'd4}) begin
      n_fail++; $display("FAIL enabled_trap got=%h exp=%h", {jisr, il, epc}, {1'b1, 5'd20, p + 32'd4});
    end
  endtask

  task automatic test_pending;
    do_reset;
    ca[15] = 1'b1; ue = 1'b1;
    tick;
    n_tests++;
    if (jisr !== 1'b0) begin n_fail++; $display("FAIL pend_pulse got=%b exp=0", jisr); end
    write_sr(32'h8000);
    n_tests++;
    if ({jisr, sr} !== {1'b0, 32'h8000}) begin n_fail++; $display("FAIL pend_srwrite got=%h exp=%h", {jisr, sr}, {1'b0, 32'h8000}); end
    ue = 1'b1;
    tick;
    n_tests++;
`ifdef INT_PEND_EN
    if ({jisr, il, eca} !== {1'b1, 5'd15, 32'h8000}) begin
      n_fail++; $display("FAIL pend_trap got=%h exp=%h", {jisr, il, eca}, {1'b1, 5'd15, 32'h8000});
    end
`else
    if ({jisr, sr} !== {1'b0, 32'h8000}) begin
      n_fail++; $display("FAIL no_pend got=%h exp=%h", {jisr, sr}, {1'b0, 32'h8000});
    end
`endif
  endtask

  task automatic test_small_config;
    do_reset;
    write_sr(32'h80);
    ca2 = 8'h80; ue = 1'b1;
    tick;
    n_tests++;
    if ({jisr2, il2, eca2} !== {1'b1, 5'd7, 32'h80}) begin
      n_fail++; $display("FAIL small_cfg got=%h exp=%h", {jisr2, il2, eca2}, {1'b1, 5'd7, 32'h80});
    end
  endtask

  task automatic test_random;
    int r;
    do_reset;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset;
      end else begin
        r = $urandom_range(0, 9);
        ca = '0; ca2 = '0;
        if (r >= 5 && r < 8)   ca[$urandom_range(NI, NC - 1)] = 1'b1;
        else if (r == 8)       ca = NC'($urandom) & NC'($urandom) & ~NC'(7'h7f);
        else if (r == 9)       ca[$urandom_range(0, NC - 1)] = 1'b1;
        ue = ($urandom_range(0, 3) != 0);
        eret = ($urandom_range(0, 4) == 0);
        sr_we = ($urandom_range(0, 5) == 0);
        sr_wdata = $urandom;
        pc = $urandom; next_pc = pc + 4; ea = $urandom;
        model_step;
        tick;
      end
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0; pc = '0; next_pc = '0; ea = '0;
    idle;
    model_reset;
    test_reset;
    test_basic_trap;
    test_priority_eret_fatal;
    test_reset_mid_trap;
    test_mask_hold;
    test_pending;
    test_small_config;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
